// File: rtl/micro_pkg.sv
// Shared constants and types for the dmem_timer peripheral: register map,
// control/status bit positions and the timer state encoding.
package micro_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned TMR_CTRL   = 0;
    localparam int unsigned TMR_PRESC  = 1;
    localparam int unsigned TMR_CMP    = 2;
    localparam int unsigned TMR_CNT    = 3;
    localparam int unsigned TMR_STATUS = 4;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_MATCH   = 0;
    localparam int unsigned STAT_RUNNING = 1;

    typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_DONE} tmr_state_t;

endpackage

// File: rtl/dmem_timer_if.sv
// Data-memory bus as seen by a responder: address, write data/strobe,
// registered read data and window-hit flag.
interface dmem_timer_if;
    import micro_pkg::*;

    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wr_dt_i;
    logic              wr_en_i;
    logic [DATA_W-1:0] rd_dt_o;
    logic              hit_o;

    modport master (output addr_i, wr_dt_i, wr_en_i, input rd_dt_o, hit_o);
    modport slave  (input addr_i, wr_dt_i, wr_en_i, output rd_dt_o, hit_o);

endinterface

// File: rtl/tmr_prescaler.sv
// Prescaler: counts enabled cycles and pulses tick_o every presc_i+1 cycles.
module tmr_prescaler #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;

    // Tick is a same-cycle decode so the timer core acts on the wrapping edge.
    assign tick_o = en_i && (cnt_q == presc_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/dmem_timer.sv
// Memory-mapped timer/compare responder on the data-memory bus with
// 1-cycle read latency and a level interrupt on compare match.
module dmem_timer
    import micro_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
    parameter int unsigned       PRESC_W   = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dmem_timer_if.slave  bus,
    output logic         irq_o
);

    tmr_state_t         state_q, state_d;
    logic               en_q, en_d;
    logic               reload_q, reload_d;
    logic               irq_en_q, irq_en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DATA_W-1:0]  cmp_q, cmp_d;
    logic [DATA_W-1:0]  cnt_q, cnt_d;
    logic               match_q, match_d;
    logic [DATA_W-1:0]  rd_d;
    logic               presc_clr;
    logic               tick;

    logic       in_win;
    logic [2:0] off;
    logic       wr_hit;
    logic       wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status;
    logic       run_tick, hw_match;

    assign in_win    = (bus.addr_i[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign off       = bus.addr_i[2:0];
    assign wr_hit    = bus.wr_en_i && in_win;
    assign wr_ctrl   = wr_hit && (off == 3'(TMR_CTRL));
    assign wr_presc  = wr_hit && (off == 3'(TMR_PRESC));
    assign wr_cmp    = wr_hit && (off == 3'(TMR_CMP));
    assign wr_cnt    = wr_hit && (off == 3'(TMR_CNT));
    assign wr_status = wr_hit && (off == 3'(TMR_STATUS));

    assign run_tick  = (state_q == TMR_RUN) && tick;
    assign hw_match  = run_tick && (cnt_q == cmp_q);

    // Prescaler restarts whenever the count sequence restarts.
    assign presc_clr = wr_cnt || (wr_ctrl && bus.wr_dt_i[CTRL_EN] && (state_q != TMR_RUN));

    tmr_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (state_q == TMR_RUN),
        .clr_i   (presc_clr),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    // Next-state, register updates and read mux; bus writes take priority over hardware.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        reload_d = reload_q;
        irq_en_d = irq_en_q;
        presc_d  = presc_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        rd_d     = '0;

        if (run_tick) begin
            if (hw_match) begin
                if (reload_q) begin
                    cnt_d = '0;
                end else begin
                    en_d    = 1'b0;
                    state_d = TMR_DONE;
                end
            end else begin
                cnt_d = cnt_q + DATA_W'(1);
            end
        end

        if (wr_ctrl) begin
            en_d     = bus.wr_dt_i[CTRL_EN];
            reload_d = bus.wr_dt_i[CTRL_RELOAD];
            irq_en_d = bus.wr_dt_i[CTRL_IRQ_EN];
            if (bus.wr_dt_i[CTRL_EN]) begin
                state_d = TMR_RUN;
                if (state_q == TMR_DONE) begin
                    cnt_d = '0;
                end
            end else begin
                state_d = TMR_IDLE;
            end
        end

        if (wr_presc) begin
            presc_d = bus.wr_dt_i[PRESC_W-1:0];
        end
        if (wr_cmp) begin
            cmp_d = bus.wr_dt_i;
        end
        if (wr_cnt) begin
            cnt_d = bus.wr_dt_i;
        end

        // A hardware match set wins over a same-cycle W1C.
        if (hw_match) begin
            match_d = 1'b1;
        end else if (wr_status && bus.wr_dt_i[STAT_MATCH]) begin
            match_d = 1'b0;
        end

        if (in_win) begin
            case (off)
                3'(TMR_CTRL):   rd_d = DATA_W'({irq_en_q, reload_q, en_q});
                3'(TMR_PRESC):  rd_d = DATA_W'(presc_q);
                3'(TMR_CMP):    rd_d = cmp_q;
                3'(TMR_CNT):    rd_d = cnt_q;
                3'(TMR_STATUS): rd_d = DATA_W'({(state_q == TMR_RUN), match_q});
                default:        rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TMR_IDLE;
            en_q        <= 1'b0;
            reload_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            presc_q     <= '0;
            cmp_q       <= '0;
            cnt_q       <= '0;
            match_q     <= 1'b0;
            bus.rd_dt_o <= '0;
            bus.hit_o   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            reload_q    <= reload_d;
            irq_en_q    <= irq_en_d;
            presc_q     <= presc_d;
            cmp_q       <= cmp_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            bus.rd_dt_o <= rd_d;
            bus.hit_o   <= in_win;
            irq_o       <= match_q && irq_en_q;
        end
    end

endmodule
